// File: rtl/gate_op_pkg.sv
// Shared definitions for the gate-op arbiter: opcode encodings and the per-bit gate function.
package gate_op_pkg;

  localparam int OP_W = 3;
  localparam int ID_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NAND = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
  localparam logic [OP_W-1:0] OP_BUF  = 3'd7;

  // Single-bit slice of the gate; the unit replicates it across the data width.
  function automatic logic gate_bit(input logic [OP_W-1:0] op, input logic a, input logic b);
    logic y;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      default: y = a;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_op_unit.sv
// Purely combinational bitwise gate over DATA_W bits.
module gate_op_unit
  import gate_op_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign y[i] = gate_bit(op, a[i], b[i]);
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one gate_op_unit among NUM_REQ requesters; grant then result one cycle later.
// Optional statistics outputs are enabled by defining GATE_OP_ARBITER_STATS_EN.
module gate_op_arbiter
  import gate_op_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [OP_W*NUM_REQ-1:0]   op_in,
  input  logic [DATA_W*NUM_REQ-1:0] a_in,
  input  logic [DATA_W*NUM_REQ-1:0] b_in,
  output logic [NUM_REQ-1:0]        gnt_out,
  output logic [DATA_W-1:0]         result_out,
  output logic                      valid_out,
  output logic [ID_W-1:0]           valid_id_out,
  output logic                      busy_out
`ifdef GATE_OP_ARBITER_STATS_EN
  ,
  output logic [15:0]               op_count_out,
  output logic [7:0]                op_seen_out
`endif
);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] req_rot;
  logic [3:0]         win_sum;
  logic [ID_W-1:0]    win;
  logic               any_req;
  logic [OP_W-1:0]    sel_op;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;

  logic               s1_valid;
  logic [ID_W-1:0]    s1_id;
  logic [OP_W-1:0]    s1_op;
  logic [DATA_W-1:0]  s1_a;
  logic [DATA_W-1:0]  s1_b;
  logic [DATA_W-1:0]  unit_y;

  // Rotate requests so bit 0 is the pointer position; the first set bit is the winner.
  always_comb begin
    req_rot = NUM_REQ'({req_in, req_in} >> ptr);
    any_req = 1'b0;
    win_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req_rot[i]) begin
        any_req = 1'b1;
        win_sum = 4'(ptr) + 4'(i);
      end
    end
    win = (win_sum >= 4'(NUM_REQ)) ? 3'(win_sum - 4'(NUM_REQ)) : 3'(win_sum);
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == 3'(i)) begin
        sel_op = op_in[i*OP_W +: OP_W];
        sel_a  = a_in[i*DATA_W +: DATA_W];
        sel_b  = b_in[i*DATA_W +: DATA_W];
      end
    end
  end

  gate_op_unit #(
    .DATA_W(DATA_W)
  ) u_unit (
    .op(s1_op),
    .a (s1_a),
    .b (s1_b),
    .y (unit_y)
  );

  // Stage 1 captures the winner's operands; stage 2 registers the gate output.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr          <= '0;
      gnt_out      <= '0;
      s1_valid     <= 1'b0;
      s1_id        <= '0;
      s1_op        <= '0;
      s1_a         <= '0;
      s1_b         <= '0;
      result_out   <= '0;
      valid_out    <= 1'b0;
      valid_id_out <= '0;
    end else begin
      gnt_out  <= '0;
      s1_valid <= 1'b0;
      if (any_req) begin
        gnt_out  <= NUM_REQ'(1) << win;
        s1_valid <= 1'b1;
        s1_id    <= win;
        s1_op    <= sel_op;
        s1_a     <= sel_a;
        s1_b     <= sel_b;
        ptr      <= (win == 3'(NUM_REQ-1)) ? '0 : win + 3'd1;
      end
      valid_out <= s1_valid;
      if (s1_valid) begin
        result_out   <= unit_y;
        valid_id_out <= s1_id;
      end
    end
  end

  assign busy_out = (|req_in) | valid_out;

`ifdef GATE_OP_ARBITER_STATS_EN
  // Counts completed operations alongside stage 2 so it tracks valid_out exactly.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      op_count_out <= '0;
      op_seen_out  <= '0;
    end else if (s1_valid) begin
      if (op_count_out != 16'hFFFF) begin
        op_count_out <= op_count_out + 16'd1;
      end
      op_seen_out[s1_op] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed self-checking bench for gate_op_arbiter with a scoreboard of expected results.
module tb_gate_op_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  typedef struct packed {
    logic [2:0]        id;
    logic [DATA_W-1:0] res;
  } exp_t;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [3*NUM_REQ-1:0]      op;
  logic [DATA_W*NUM_REQ-1:0] a;
  logic [DATA_W*NUM_REQ-1:0] b;
  logic [NUM_REQ-1:0]        gnt_out;
  logic [DATA_W-1:0]         result_out;
  logic                      valid_out;
  logic [2:0]                valid_id_out;
  logic                      busy_out;
`ifdef GATE_OP_ARBITER_STATS_EN
  logic [15:0]               op_count_out;
  logic [7:0]                op_seen_out;
`endif

  exp_t               sb[$];
  int                 model_ptr;
  logic [NUM_REQ-1:0] auto_drop;
  logic [DATA_W-1:0]  last_result;
  logic [DATA_W-1:0]  op_tbl [8];
  int                 tests;
  int                 fails;

  gate_op_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .req_in      (req),
    .op_in       (op),
    .a_in        (a),
    .b_in        (b),
    .gnt_out     (gnt_out),
    .result_out  (result_out),
    .valid_out   (valid_out),
    .valid_id_out(valid_id_out),
    .busy_out    (busy_out)
`ifdef GATE_OP_ARBITER_STATS_EN
    ,
    .op_count_out(op_count_out),
    .op_seen_out (op_seen_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] model_gate(input logic [2:0] o, input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return ~(x & y);
      3'd3:    return ~(x | y);
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input logic rst_s, input logic [NUM_REQ-1:0] exp_gnt, input int g,
                             input exp_t e);
    logic exp_valid;
    exp_t p;
    exp_valid = (sb.size() > 0) && !rst_s;
    check("busy", {31'd0, busy_out}, {31'd0, (|req) | exp_valid});
    if (rst_s) begin
      sb.delete();
      model_ptr   = 0;
      last_result = '0;
      check("rst_gnt", 32'(gnt_out), 32'd0);
      check("rst_valid", {31'd0, valid_out}, 32'd0);
      check("rst_result", 32'(result_out), 32'd0);
      check("rst_id", 32'(valid_id_out), 32'd0);
    end else begin
      check("gnt", 32'(gnt_out), 32'(exp_gnt));
      if (exp_valid) begin
        p = sb.pop_front();
        check("valid", {31'd0, valid_out}, 32'd1);
        check("result", 32'(result_out), 32'(p.res));
        check("valid_id", 32'(valid_id_out), 32'(p.id));
        last_result = p.res;
      end else begin
        check("valid_idle", {31'd0, valid_out}, 32'd0);
        check("result_hold", 32'(result_out), 32'(last_result));
      end
      if (g >= 0) begin
        sb.push_back(e);
        model_ptr = (g + 1) % NUM_REQ;
        if (auto_drop[g]) req[g] = 1'b0;
      end
    end
  endtask

  // One clock: predict the grant from the driven requests, then check after the edge.
  task automatic applyStimulus();
    int g;
    int idx;
    logic [NUM_REQ-1:0] exp_gnt;
    logic rst_s;
    exp_t e;
    g       = -1;
    exp_gnt = '0;
    e       = '0;
    rst_s   = rst;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (model_ptr + k) % NUM_REQ;
        if (g < 0 && req[idx]) g = idx;
      end
    end
    if (g >= 0) begin
      exp_gnt[g] = 1'b1;
      e.id  = 3'(g);
      e.res = model_gate(op[3*g +: 3], a[DATA_W*g +: DATA_W], b[DATA_W*g +: DATA_W]);
    end
    @(posedge clk);
    #1;
    checkOutput(rst_s, exp_gnt, g, e);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_ptr = 0;
    last_result = '0;
    op_tbl[0] = 8'h05; op_tbl[1] = 8'hAF; op_tbl[2] = 8'hFA; op_tbl[3] = 8'h50;
    op_tbl[4] = 8'hAA; op_tbl[5] = 8'h55; op_tbl[6] = 8'h5A; op_tbl[7] = 8'hA5;
    rst = 1'b1;
    req = '0;
    op  = '0;
    a   = '0;
    b   = '0;
    auto_drop = '1;

    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();

    // All eight opcodes on requester 0 against the fixed reference values.
    for (int o = 0; o < 8; o++) begin
      op[2:0] = 3'(o);
      a[7:0]  = 8'hA5;
      b[7:0]  = 8'h0F;
      req[0]  = 1'b1;
      applyStimulus();
      applyStimulus();
      check($sformatf("op_tbl%0d", o), 32'(result_out), 32'(op_tbl[o]));
    end
    applyStimulus();

    // Reset wins over simultaneous requests, then all four requesters stay high.
    for (int i = 0; i < NUM_REQ; i++) begin
      op[3*i +: 3]           = 3'(i + 2);
      a[DATA_W*i +: DATA_W]  = 8'($urandom);
      b[DATA_W*i +: DATA_W]  = 8'($urandom);
    end
    rst = 1'b1;
    req = '1;
    auto_drop = '0;
    applyStimulus();
    rst = 1'b0;
    for (int c = 0; c < 2 * NUM_REQ; c++) applyStimulus();
    req = '0;
    auto_drop = '1;
    applyStimulus();
    applyStimulus();

    // Move pointer to 2, then requests on 1 and 3 must grant 3 before 1.
    req = 4'b0010;
    applyStimulus();
    req = 4'b1010;
    applyStimulus();
    applyStimulus();
    req = 4'b0110;
    applyStimulus();
    applyStimulus();
    applyStimulus();

    // Requester 2 withdraws while 0 is being granted.
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    req = 4'b1101;
    applyStimulus();
    req[2] = 1'b0;
    applyStimulus();
    applyStimulus();

    // Reset right after a grant discards the in-flight result and the pointer.
    req = 4'b0010;
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    req = 4'b0101;
    applyStimulus();
    applyStimulus();
    applyStimulus();

`ifdef GATE_OP_ARBITER_STATS_EN
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    check("stats_rst_count", 32'(op_count_out), 32'd0);
    for (int k = 0; k < 5; k++) begin
      op[2:0] = (k < 3) ? 3'd0 : 3'd4;
      a[7:0]  = 8'($urandom);
      b[7:0]  = 8'($urandom);
      req[0]  = 1'b1;
      applyStimulus();
      applyStimulus();
    end
    check("op_count", 32'(op_count_out), 32'd5);
    check("op_seen", 32'(op_seen_out), 32'h11);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    check("op_count_clr", 32'(op_count_out), 32'd0);
    check("op_seen_clr", 32'(op_seen_out), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gate_op_arbiter.md
Name: gate_op_arbiter

Overview:
- Shares one bitwise logic-gate unit among NUM_REQ requesters: AND, OR, NAND, NOR, XOR, XNOR, NOT, BUF.
- A round-robin arbiter grants one request per cycle and captures its opcode and operands.
- The result is registered and returned one cycle after grant, tagged with the requester index.
- Sits between multiple gate-exercising clients and a single shared gate datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand/result width in bits.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  synchronous reset, active-high.
- req_in  input  NUM_REQ  per-requester request level.
- op_in  input  3*NUM_REQ  per-requester opcode; requester i uses bits [3i+2:3i].
- a_in  input  DATA_W*NUM_REQ  per-requester operand A; slice i.
- b_in  input  DATA_W*NUM_REQ  per-requester operand B; slice i.
- gnt_out  output  NUM_REQ  one-hot grant pulse, one cycle.
- result_out  output  DATA_W  registered gate result.
- valid_out  output  1  result_out valid pulse.
- valid_id_out  output  3  index of requester owning result_out.
- busy_out  output  1  high while any req_in is high or valid_out is high.

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - gnt_out=0, result_out=0, valid_out=0, valid_id_out=0.
  - Round-robin pointer=0.
  - Any in-flight result is discarded; nothing is emitted after reset.
- Opcodes (bitwise over DATA_W):
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT A (B ignored), 7 BUF A (B ignored).
- Handshake:
  - A requester holds req_in high with op/a/b stable until it sees gnt_out[i]=1.
  - Operands are sampled on the grant edge.
  - If req_in[i] is still high in the cycle after the grant, it is a new request.
- Arbitration: registered, grant in cycle after req_in sampled.
  - Search starts at pointer, ascending with wrap to 0.
  - The first asserted req_in wins; exactly one gnt bit is high.
  - After granting index g, pointer = (g+1) mod NUM_REQ.
  - With no requests, the pointer holds.
- Throughput: one grant per cycle. Back-to-back grants to different requesters are allowed.
- Pipeline:
  - Stage 1, edge k: gnt_out asserted; op/a/b latched.
  - Stage 2, edge k+1: result_out = f(op,a,b), valid_out=1, valid_id_out=g.
  - Latency from grant to valid is 1 cycle.
- result_out holds its last value when valid_out=0.
- The requester withdrawing req_in before grant is legal; no grant is issued to it.
- Simultaneous requests from all NUM_REQ:
  - Each is served exactly once per NUM_REQ consecutive grants, in order from the pointer.
- Reset in same cycle as requests: reset wins, no grant.

Optional Feature:
- Macro GATE_OP_ARBITER_STATS_EN.
- Defined:
  - Adds output op_count_out (16 bits), incremented on every valid_out, saturating at 0xFFFF.
  - Cleared by rst_in.
  - Adds output per-opcode hit vector op_seen_out (8 bits): bit n sets sticky when opcode n completes.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package gate_op_pkg:
  - Opcode localparams OP_AND..OP_BUF (3-bit).
  - OP_W=3.
  - The function computing the gate result from op/a/b.
- Sub-module gate_op_unit: purely combinational op/a/b→y over DATA_W. The arbiter instantiates one gate_op_unit between stage 1 and stage 2.

Test Plan:
- Single request, all 8 ops:
  - Stimulus: requester 0, a=0xA5, b=0x0F.
  - Expected results: AND 0x05, OR 0xAF, NAND 0xFA, NOR 0x50, XOR 0xAA, XNOR 0x55, NOT 0x5A, BUF 0xA5.
  - Each result has valid_id_out=0, one cycle after grant.
- All 4 requesters high from reset:
  - Grants 0,1,2,3,0,… in consecutive cycles.
  - valid_id_out follows the same sequence delayed by 1.
- Requests on 1 and 3 only, pointer=2:
  - Grant 3 first, then 1.
  - Pointer then 2.
- Requester 2 drops req_in before grant while 0 is being granted:
  - No gnt_out[2].
  - The next grant goes to the next asserted requester.
- rst_in asserted the cycle after a grant:
  - No valid_out.
  - All outputs 0.
  - The next grant after release goes to requester 0 first.
- With GATE_OP_ARBITER_STATS_EN:
  - Issue 5 ops (AND×3, XOR×2).
  - op_count_out=5 and op_seen_out=0x11.
  - Reset returns both to 0.
